// File: rtl/reg_file_2r1w_pkg.sv
// cpu_pkg: shared datapath widths, zero-register index and ALU control encodings.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: read/write port bundle between datapath control and the register file.
interface reg_file_2r1w_if;
    import cpu_pkg::*;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              reg_write;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    modport master (output rs_addr, rt_addr, rd_addr, rd_data, reg_write, input rs_data, rt_data);
    modport slave  (input rs_addr, rt_addr, rd_addr, rd_data, reg_write, output rs_data, rt_data);
endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// reg_read_port: combinational read mux with zero-register force.
// REGFILE_WRITE_BYPASS_EN adds write-first forwarding of the in-flight write.
module reg_read_port
    import cpu_pkg::*;
(
    output logic [DATA_W-1:0] data,
    input  logic              rst,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] addr
`ifdef REGFILE_WRITE_BYPASS_EN
    ,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
`endif
);
    always_comb begin
`ifdef REGFILE_WRITE_BYPASS_EN
        data = (!rst || addr == REG_ZERO) ? '0 : (wr_en && wr_addr == addr) ? wr_data : regs[addr];
`else
        data = (!rst || addr == REG_ZERO) ? '0 : regs[addr];
`endif
    end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 register file, two combinational read ports, one write port, r0 hardwired to 0.
// Optional REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_2r1w
    import cpu_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reg_file_2r1w_if.slave  bus
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_live
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    regs[g] <= '0;
                else if (bus.reg_write && bus.rd_addr == ADDR_W'(g))
                    regs[g] <= bus.rd_data;
            end
        end
    end
    reg_read_port u_rs (
        .data    (bus.rs_data),
        .rst     (rst),
        .regs    (regs),
        .addr    (bus.rs_addr)
`ifdef REGFILE_WRITE_BYPASS_EN
        ,
        .wr_en   (bus.reg_write),
        .wr_addr (bus.rd_addr),
        .wr_data (bus.rd_data)
`endif
    );
    reg_read_port u_rt (
        .data    (bus.rt_data),
        .rst     (rst),
        .regs    (regs),
        .addr    (bus.rt_addr)
`ifdef REGFILE_WRITE_BYPASS_EN
        ,
        .wr_en   (bus.reg_write),
        .wr_addr (bus.rd_addr),
        .wr_data (bus.rd_data)
`endif
    );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed scoreboard bench for reg_file_2r1w in either bypass build.
module tb_reg_file_2r1w;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    logic [DATA_W-1:0] exp_q [$];
    string             tag_q [$];
    logic [DATA_W:0]   alu_r;
    reg_file_2r1w_if bus ();
    reg_file_2r1w dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rst && bus.reg_write) begin
            total++;
            assert (!$isunknown(bus.rd_addr)) else begin
                bad++;
                $error("FAIL rd_addr_known observed=%b expected=known", bus.rd_addr);
            end
        end
    end
    function automatic logic [DATA_W:0] alu(alu_ctrl_e c, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (c)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR: r = ~(a | b);
            default: r = '0;
        endcase
        return {r == '0, r};
    endfunction
    task automatic push(input string t, input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask
    task automatic check(input logic [DATA_W-1:0] obs);
        string t;
        logic [DATA_W-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=queued", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.reg_write = 1'b1;
        bus.rd_addr = a;
        bus.rd_data = d;
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
    endtask
    initial begin
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rd_addr = '0; bus.rd_data = '0; bus.reg_write = 1'b0;
        #12;
        bus.rs_addr = 5'd7; bus.rt_addr = 5'd31;
        push("reset_rs", 32'h0); push("reset_rt", 32'h0);
        #1 check(bus.rs_data); check(bus.rt_data);
        @(negedge clk) rst = 1'b1;
        wr(5'd5, 32'hDEADBEEF);
        bus.rs_addr = 5'd5;
        push("pre_reset_r5", 32'hDEADBEEF);
        #1 check(bus.rs_data);
        rst = 1'b0;
        push("async_reset_r5", 32'h0);
        #1 check(bus.rs_data);
        @(negedge clk);
        bus.reg_write = 1'b1; bus.rd_addr = 5'd6; bus.rd_data = 32'h00001234;
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        @(negedge clk) rst = 1'b1;
        bus.rt_addr = 5'd6;
        push("after_reset_r5", 32'h0); push("write_in_reset_r6", 32'h0);
        #1 check(bus.rs_data); check(bus.rt_data);
        wr(5'd8, 32'h12345678);
        bus.rs_addr = 5'd8; bus.rt_addr = 5'd8;
        push("basic_rs_r8", 32'h12345678); push("basic_rt_r8", 32'h12345678);
        #1 check(bus.rs_data); check(bus.rt_data);
        bus.rs_addr = 5'd9;
        push("basic_r9_untouched", 32'h0);
        #1 check(bus.rs_data);
        @(negedge clk);
        bus.reg_write = 1'b1; bus.rd_addr = 5'd0; bus.rd_data = 32'hFFFFFFFF;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
        push("r0_before_edge_rs", 32'h0); push("r0_before_edge_rt", 32'h0);
        #1 check(bus.rs_data); check(bus.rt_data);
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        push("r0_after_edge", 32'h0);
        #1 check(bus.rs_data);
        @(negedge clk);
        bus.rd_addr = 5'd3; bus.rd_data = 32'hAAAA5555;
        repeat (4) @(posedge clk);
        #1 bus.rs_addr = 5'd3;
        push("we_gated_r3", 32'h0);
        #1 check(bus.rs_data);
        wr(5'd4, 32'd7);
        @(negedge clk);
        bus.reg_write = 1'b1; bus.rd_addr = 5'd4; bus.rd_data = 32'd9;
        bus.rs_addr = 5'd4; bus.rt_addr = 5'd4;
`ifdef REGFILE_WRITE_BYPASS_EN
        push("hazard_before_rs", 32'd9); push("hazard_before_rt", 32'd9);
`else
        push("hazard_before_rs", 32'd7); push("hazard_before_rt", 32'd7);
`endif
        #1 check(bus.rs_data); check(bus.rt_data);
        @(posedge clk);
        #1 bus.reg_write = 1'b0;
        push("hazard_after_rs", 32'd9);
        #1 check(bus.rs_data);
        wr(5'd1, 32'hFFFFFFFE);
        wr(5'd2, 32'd3);
        bus.rs_addr = 5'd1; bus.rt_addr = 5'd2;
        push("alu_src1", 32'hFFFFFFFE); push("alu_src2", 32'd3);
        #1 check(bus.rs_data); check(bus.rt_data);
        alu_r = alu(ALU_SLT, bus.rs_data, bus.rt_data);
        push("alu_slt_result", 32'd1);
        check(alu_r[DATA_W-1:0]);
        alu_r = alu(ALU_ADD, bus.rs_data, bus.rt_data);
        push("alu_add_result", 32'd1); push("alu_add_zero", 32'd0);
        check(alu_r[DATA_W-1:0]);
        check({31'd0, alu_r[DATA_W]});
        if (exp_q.size() != 0) begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
